// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer: random-delay stimulus lamp, ms response timing,
// cheat detection, and an average/best summary shown on a 4-digit display.
module reaction_timer_multi #(
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          ROUNDS       = 4,
    parameter int          MIN_DELAY_MS = 1000,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clear_btn,
    output logic       led0,
    output logic       ltr_flag,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] round_o,
    output logic       cheat,
    output logic       done,
    output logic       show_best
);

    localparam int          TICK_DIV = CLK_HZ / 1000;
    localparam int          PW       = $clog2(TICK_DIV);
    localparam int          DW       = $clog2(MIN_DELAY_MS + 4096);
    localparam int          LOG2_R   = $clog2(ROUNDS);
    localparam logic [3:0]  ROUNDS_L = 4'(ROUNDS);
    localparam logic [13:0] MAX_MS   = 14'd9999;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT, S_TIMING, S_SHOW, S_CHEAT, S_SUMMARY
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     lfsr;
    logic            lfsr_fb;
    logic [PW-1:0]   presc;
    logic            tick;
    logic            enter_count;
    logic [DW-1:0]   delay;
    logic [13:0]     ms_cnt, round_time, best, rt_new, avg, disp_bin;
    logic [16:0]     sum;
    logic            numeric;
    logic [15:0]     letters;

    function automatic logic [15:0] to_bcd(input logic [13:0] v);
        return {4'(v / 14'd1000), 4'((v / 14'd100) % 14'd10),
                4'((v / 14'd10) % 14'd10), 4'(v % 14'd10)};
    endfunction

    // Fibonacci taps 16,14,13,11
    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign enter_count = (state_nxt != state) &&
                         (state_nxt == S_WAIT || state_nxt == S_TIMING);
    // A round ending without stop_btn can only be the 9999 ms saturation.
    assign rt_new      = stop_btn ? ms_cnt : MAX_MS;
    assign avg         = 14'(sum >> LOG2_R);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (clear_btn) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start_btn) state_nxt = S_ARM;
                S_ARM:     state_nxt = S_WAIT;
                S_WAIT:    if (stop_btn) state_nxt = S_CHEAT;
                           else if (delay == '0) state_nxt = S_TIMING;
                S_TIMING:  if (stop_btn || (tick && ms_cnt == MAX_MS - 14'd1))
                               state_nxt = S_SHOW;
                S_SHOW:    if (start_btn)
                               state_nxt = (round_o == ROUNDS_L) ? S_SUMMARY : S_ARM;
                S_CHEAT:   if (start_btn) state_nxt = S_ARM;
                S_SUMMARY: if (start_btn) state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            lfsr       <= SEED;
            presc      <= '0;
            delay      <= '0;
            ms_cnt     <= '0;
            round_time <= '0;
            sum        <= '0;
            best       <= '0;
            round_o    <= '0;
            show_best  <= 1'b0;
            led0       <= 1'b0;
            cheat      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= {lfsr[14:0], lfsr_fb};
            presc <= (enter_count || tick) ? '0 : presc + PW'(1);
            led0  <= (state_nxt == S_TIMING) || (state_nxt == S_SHOW);
            cheat <= (state_nxt == S_CHEAT);
            done  <= (state_nxt == S_SUMMARY);

            case (state)
                S_ARM:    delay <= DW'(MIN_DELAY_MS) + DW'(lfsr[11:0]);
                S_WAIT:   if (tick && delay != '0) delay <= delay - DW'(1);
                S_TIMING: if (tick) ms_cnt <= ms_cnt + 14'd1;
                default:  ;
            endcase
            if (enter_count && state_nxt == S_TIMING)
                ms_cnt <= '0;

            if (state == S_TIMING && state_nxt == S_SHOW) begin
                round_time <= rt_new;
                sum        <= sum + 17'(rt_new);
                round_o    <= round_o + 4'd1;
                if (round_o == 4'd0 || rt_new < best)
                    best <= rt_new;
            end

            if (clear_btn || (state == S_IDLE && state_nxt == S_ARM)) begin
                sum       <= '0;
                best      <= '0;
                round_o   <= '0;
                show_best <= 1'b0;
            end else if (state == S_SUMMARY && stop_btn && !start_btn) begin
                show_best <= ~show_best;
            end
        end
    end

    always_comb begin
        numeric  = 1'b0;
        letters  = 16'hFFFF;
        disp_bin = round_time;
        case (state)
            S_IDLE:    letters = 16'hFF5A;
            S_ARM,
            S_WAIT:    letters = 16'hFFFF;
            S_TIMING:  begin numeric = 1'b1; disp_bin = ms_cnt; end
            S_SHOW:    numeric = 1'b1;
            S_CHEAT:   letters = 16'hCCCC;
            S_SUMMARY: begin numeric = 1'b1; disp_bin = show_best ? best : avg; end
            default:   letters = 16'hFF5A;
        endcase
        ltr_flag = ~numeric;
        {digit3, digit2, digit1, digit0} = numeric ? to_bcd(disp_bin) : letters;
    end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Scoreboard bench for reaction_timer_multi: stimulus queues expected output
// snapshots, a negedge monitor pops one per observed output change.
module tb_reaction_timer_multi;

    localparam int          MS     = 10;      // cycles per ms at CLK_HZ = 10000
    localparam int          ROUNDS = 2;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic clk, rst;
    logic start_btn, stop_btn, clear_btn;
    logic led0, ltr_flag, cheat, done, show_best;
    logic [3:0] digit0, digit1, digit2, digit3, round_o;

    logic f_start;
    logic f_led0, f_ltr, f_cheat, f_done, f_best;
    logic [3:0] f_d0, f_d1, f_d2, f_d3, f_round;

    reaction_timer_multi #(.CLK_HZ(10000), .ROUNDS(ROUNDS), .MIN_DELAY_MS(1), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn), .clear_btn(clear_btn),
        .led0(led0), .ltr_flag(ltr_flag), .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .digit3(digit3), .round_o(round_o), .cheat(cheat), .done(done), .show_best(show_best));

    // 2 cycles/ms instance, used only for the 9999 ms saturation run
    reaction_timer_multi #(.CLK_HZ(2000), .ROUNDS(ROUNDS), .MIN_DELAY_MS(1), .SEED(SEED)) dut_fast (
        .clk(clk), .rst(rst), .start_btn(f_start), .stop_btn(1'b0), .clear_btn(1'b0),
        .led0(f_led0), .ltr_flag(f_ltr), .digit0(f_d0), .digit1(f_d1), .digit2(f_d2),
        .digit3(f_d3), .round_o(f_round), .cheat(f_cheat), .done(f_done), .show_best(f_best));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        string       name;
        logic [24:0] v;
        int          cyc;   // -1: cycle not checked
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [15:0] lfsr_m;
    int          q_times[$];
    int          m_round;
    bit          m_sb;
    bit          mon_en = 1'b0;
    logic [24:0] prev_trig;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];   // taps 16,14,13,11
        return {s[14:0], fb};
    endfunction

    function automatic logic [15:0] dec4(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int m_sum();
        int s = 0;
        foreach (q_times[i]) s += q_times[i];
        return s;
    endfunction

    function automatic int m_best();
        int b = 99999;
        foreach (q_times[i]) if (q_times[i] < b) b = q_times[i];
        return b;
    endfunction

    always @(posedge clk) cyc++;
    always @(posedge clk or posedge rst)
        if (rst) lfsr_m = SEED;
        else     lfsr_m = lfsr_step(lfsr_m);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input string name, input bit l0, input bit lt, input logic [15:0] dg,
                        input int rd, input bit ch, input bit dn, input bit bs, input int c);
        exp_t e;
        e.name = name;
        e.v    = {l0, lt, 4'(rd), ch, dn, bs, dg};
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Output-change monitor: letter digits are static, numeric ones only count when flags change.
    always @(negedge clk) begin
        logic [24:0] full, trig;
        exp_t e;
        full = {led0, ltr_flag, round_o, cheat, done, show_best, digit3, digit2, digit1, digit0};
        trig = ltr_flag ? full : {full[24:16], 16'h0};
        if (mon_en && trig !== prev_trig) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_event: outputs %0h at cycle %0d, none expected", full, cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_outputs"}, 64'(full), 64'(e.v));
                if (e.cyc >= 0) check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
        prev_trig = trig;
    end

    task automatic pulse(input bit s, input bit p, input bit c);
        start_btn = s; stop_btn = p; clear_btn = c;
        @(negedge clk);
        start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Hold off the start press until the model predicts a short delay.
    task automatic wait_small();
        logic [15:0] nl;
        int k = 0;
        nl = lfsr_step(lfsr_m);
        while (nl[11:0] >= 12'd40 && k < 20000) begin
            @(negedge clk);
            k++;
            nl = lfsr_step(lfsr_m);
        end
        if (k >= 20000) check("wait_small_bound", 64'(k), 64'(0));
    endtask

    task automatic begin_session();
        m_round = 0;
        m_sb    = 1'b0;
        q_times.delete();
    endtask

    task automatic start_round(input bit exp_timing, input bit with_stop,
                               output int t_entry, output int d_ms);
        logic [15:0] nl;
        int n;
        nl      = lfsr_step(lfsr_m);
        d_ms    = 1 + int'(nl[11:0]);
        n       = cyc;
        t_entry = n + 3 + MS * d_ms;
        push("arm", 1'b0, 1'b1, 16'hFFFF, m_round, 1'b0, 1'b0, m_sb, n + 1);
        if (exp_timing)
            push("timing", 1'b1, 1'b0, 16'h0000, m_round, 1'b0, 1'b0, m_sb, t_entry);
        pulse(1'b1, with_stop, 1'b0);
    endtask

    task automatic respond(input int t_entry, input int r);
        int t;
        wait_until(t_entry + r);
        t = r / MS;
        q_times.push_back(t);
        m_round++;
        push("show", 1'b1, 1'b0, dec4(t), m_round, 1'b0, 1'b0, m_sb, t_entry + r + 1);
        pulse(1'b0, 1'b1, 1'b0);
    endtask

    task automatic summary(input bit toggle_back);
        int avg;
        avg = m_sum() / ROUNDS;
        push("summary", 1'b0, 1'b0, dec4(avg), m_round, 1'b0, 1'b1, m_sb, cyc + 1);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        m_sb = 1'b1;
        push("show_best", 1'b0, 1'b0, dec4(m_best()), m_round, 1'b0, 1'b1, m_sb, cyc + 1);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        if (toggle_back) begin
            m_sb = 1'b0;
            push("show_avg", 1'b0, 1'b0, dec4(avg), m_round, 1'b0, 1'b1, m_sb, cyc + 1);
            pulse(1'b0, 1'b1, 1'b0);
            repeat (3) @(negedge clk);
        end
        push("to_idle", 1'b0, 1'b1, 16'hFF5A, m_round, 1'b0, 1'b0, m_sb, cyc + 1);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t, d, m, s, k;
        rst = 1'b1;
        start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0; f_start = 1'b0;
        m_round = 0; m_sb = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_digits", 64'({digit3, digit2, digit1, digit0}), 64'(16'hFF5A));
        check("reset_flags", 64'({led0, ltr_flag, cheat, done, show_best, round_o}),
              64'({1'b0, 1'b1, 3'b000, 4'd0}));
        @(negedge clk);
        rst = 1'b0;
        #1 mon_en = 1'b1;

        // No button: must stay in IDLE
        repeat (50) @(negedge clk);
        check("idle_hold", 64'({ltr_flag, digit3, digit2, digit1, digit0}), 64'({1'b1, 16'hFF5A}));

        // 250 ms response
        wait_small();
        begin_session();
        start_round(1'b1, 1'b0, t, d);
        respond(t, 2500);
        repeat (5) @(negedge clk);

        // start+stop in SHOW: start wins; then start+stop in WAIT: stop wins (cheat)
        wait_small();
        start_round(1'b0, 1'b1, t, d);
        m = t - 1 - $urandom_range(0, MS * d);
        wait_until(m);
        push("cheat", 1'b0, 1'b1, 16'hCCCC, m_round, 1'b1, 1'b0, m_sb, m + 1);
        pulse(1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        // From CHEAT back to ARM, 101 ms response, then summary 175 / best 101
        wait_small();
        start_round(1'b1, 1'b0, t, d);
        respond(t, 1010);
        repeat (5) @(negedge clk);
        summary(1'b1);

        // Randomized sessions
        for (int sess = 0; sess < 2; sess++) begin
            wait_small();
            begin_session();
            for (int r = 0; r < ROUNDS; r++) begin
                if (r > 0) wait_small();
                start_round(1'b1, 1'b0, t, d);
                respond(t, $urandom_range(0, 1500));
                repeat (4) @(negedge clk);
            end
            summary(1'(sess));
        end

        // clear_btn with stop_btn in TIMING of round 2
        wait_small();
        begin_session();
        start_round(1'b1, 1'b0, t, d);
        respond(t, $urandom_range(0, 1500));
        repeat (4) @(negedge clk);
        wait_small();
        start_round(1'b1, 1'b0, t, d);
        m = t + $urandom_range(0, 500);
        wait_until(m);
        begin_session();
        push("clear", 1'b0, 1'b1, 16'hFF5A, 0, 1'b0, 1'b0, 1'b0, m + 1);
        pulse(1'b0, 1'b1, 1'b1);
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of WAIT
        wait_small();
        begin_session();
        start_round(1'b0, 1'b0, t, d);
        wait_until(t - 3 - MS * d + 6);
        push("rst_idle", 1'b0, 1'b1, 16'hFF5A, 0, 1'b0, 1'b0, 1'b0, -1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_digits", 64'({digit3, digit2, digit1, digit0}), 64'(16'hFF5A));
        check("rstmid_flags", 64'({led0, ltr_flag, cheat, done, show_best, round_o}),
              64'({1'b0, 1'b1, 3'b000, 4'd0}));
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        // Delay of this round only matches if the LFSR restarted from SEED
        wait_small();
        begin_session();
        start_round(1'b1, 1'b0, t, d);
        respond(t, $urandom_range(0, 1500));
        repeat (5) @(negedge clk);

        // Saturation at 9999 ms on the 2 cycles/ms instance
        f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
        k = 0;
        while (!f_led0 && k < 10000) begin @(negedge clk); k++; end
        check("sat_led0_seen", 64'(f_led0), 64'(1));
        t = cyc;
        k = 0;
        while (f_round != 4'd1 && k < 25000) begin @(negedge clk); k++; end
        s = cyc;
        check("sat_latency", 64'(s - t), 64'(19998));
        check("sat_digits", 64'({f_ltr, f_d3, f_d2, f_d1, f_d0}), 64'({1'b0, 16'h9999}));
        check("sat_led0_show", 64'(f_led0), 64'(1));

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
